mux2_arbiter: RTL and testbench
===============================

MUX2_ARBITER -- requirements
Module: mux2_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8: the maximum number of consecutive grant cycles while the other requester waits (legal range 2..15).
REQ-002 The block SHALL have parameter CNT_W, default 4: the width of the hold counter, which must hold MAX_HOLD.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port req_a, input, 1 bit: requester A wants the shared mux path, level-sensitive.
REQ-006 Port req_b, input, 1 bit: requester B wants the shared mux path, level-sensitive.
REQ-007 Port a, input, 1 bit: requester A data.
REQ-008 Port b, input, 1 bit: requester B data.
REQ-009 Port gnt_a, output, 1 bit: A owns the path; registered.
REQ-010 Port gnt_b, output, 1 bit: B owns the path; registered.
REQ-011 Port x, output, 1 bit: mux select, 0 selects a and 1 selects b; registered.
REQ-012 Port y, output, 1 bit: shared path output, y = x ? b : a, combinational from the registered x.
REQ-013 Port busy, output, 1 bit: high when gnt_a or gnt_b is high.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, OWN_A and OWN_B. gnt_a is high only in OWN_A; gnt_b is high only in OWN_B; gnt_a and gnt_b are never high together.
REQ-015 Grant latency SHALL be 1 cycle: a request sampled at edge N gives a grant visible after edge N.
REQ-016 IDLE transitions:
- only req_a goes to OWN_A;
- only req_b goes to OWN_B;
- both requests go to the requester that is not last_gnt (round-robin);
- no request stays in IDLE.
REQ-017 OWN_A SHALL hold while req_a=1. When req_a=0, it goes to OWN_B if req_b=1, else to IDLE; the handover is direct, with no idle bubble.
REQ-018 OWN_B SHALL behave symmetrically to OWN_A.
REQ-019 last_gnt SHALL be an internal 1-bit register set to the owner on every entry into OWN_A or OWN_B.
REQ-020 x SHALL update together with the state: 0 in OWN_A, 1 in OWN_B, and it keeps its previous value in IDLE, so y does not glitch on release.
REQ-021 hold_cnt SHALL reset to 1 on entry into an OWN state, increment each cycle the owner is retained, and saturate at MAX_HOLD.
REQ-022 A request that drops and re-rises in the same cycle as the other requester's request SHALL be resolved by round-robin, not by the previous owner.

Reset
REQ-023 While rst_n=0 at a clock edge, the block SHALL set state=IDLE, gnt_a=0, gnt_b=0, x=0, busy=0, hold_cnt=0 and last_gnt=B, so A wins the first tie.
REQ-024 A reset asserted mid-grant SHALL drop the grant on that same edge; requests are ignored until the first edge with rst_n=1.

Configuration
REQ-025 With macro MUX2_ARB_TIMEOUT_EN defined, an owner that has held the grant for MAX_HOLD cycles while the other requester is high SHALL lose the grant on the next edge, which passes directly to the other requester; hold_cnt restarts at 1.
REQ-026 With MUX2_ARB_TIMEOUT_EN undefined, hold_cnt logic SHALL be absent and an owner SHALL keep the grant for as long as its request stays high.

Verification
REQ-027 Reset test: rst_n=0 for 2 cycles with req_a=req_b=1 -> gnt_a=gnt_b=0, x=0, busy=0; on the first edge after release -> gnt_a=1, x=0.
REQ-028 Single requester: req_b=1 alone, b=1, a=0 -> one cycle later gnt_b=1, x=1, y=1; req_b drops -> IDLE, x stays 1.
REQ-029 Round-robin: req_a=req_b=1 from IDLE with last_gnt=A -> OWN_B; req_b drops -> next edge OWN_A with no IDLE cycle.
REQ-030 Timeout with macro defined and MAX_HOLD=8: req_a held, req_b rises -> gnt_a for exactly 8 cycles, then gnt_b=1, x=1.
REQ-031 Without the macro: same stimulus as REQ-030 -> gnt_a held for 50 cycles with no switch.
REQ-032 Mid-grant reset: rst_n=0 during OWN_B -> gnt_b=0, x=0 on that edge.

Source files
------------

// File: rtl/mux2_arbiter.sv
// Two-requester round-robin arbiter steering a shared 2:1 mux path.
// Define MUX2_ARB_TIMEOUT_EN to force handover after MAX_HOLD contended cycles.
module mux2_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic a,
  input  logic b,
  output logic gnt_a,
  output logic gnt_b,
  output logic x,
  output logic y,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_e;

  localparam logic LG_A = 1'b0;
  localparam logic LG_B = 1'b1;

  state_e state_q;
  state_e state_d;
  logic   x_q;
  logic   x_d;
  logic   last_q;
  logic   last_d;
  logic   enter_a;
  logic   enter_b;
  logic   to_a;
  logic   to_b;

`ifdef MUX2_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  logic [CNT_W-1:0] hold_q;
  logic [CNT_W-1:0] hold_d;
  logic [CNT_W-1:0] hold_inc;
  logic             hold_sat;
  logic             retained;

  assign hold_sat = (hold_q >= HOLD_MAX);
  assign hold_inc = hold_sat ? HOLD_MAX
                             : hold_q + CNT_W'(1);
  assign to_a     = hold_sat & req_b;
  assign to_b     = hold_sat & req_a;
  assign retained = (state_q != IDLE)
                  & (state_d == state_q);

  always_comb begin
    hold_d = hold_q;
    if (enter_a || enter_b) begin
      hold_d = CNT_W'(1);
    end else if (retained) begin
      hold_d = hold_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign to_a = 1'b0;
  assign to_b = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    enter_a = 1'b0;
    enter_b = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          req_a & ~req_b: enter_a = 1'b1;
          ~req_a & req_b: enter_b = 1'b1;
          req_a & req_b: begin
            // tie goes to whoever did not own last
            if (last_q == LG_B) begin
              enter_a = 1'b1;
            end else begin
              enter_b = 1'b1;
            end
          end
          default: ;
        endcase
      end
      OWN_A: begin
        if (!req_a || to_a) begin
          if (req_b) begin
            enter_b = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      OWN_B: begin
        if (!req_b || to_b) begin
          if (req_a) begin
            enter_a = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (enter_a) begin
      state_d = OWN_A;
    end
    if (enter_b) begin
      state_d = OWN_B;
    end
  end

  // select only moves on a grant, so release keeps y steady
  always_comb begin
    x_d    = x_q;
    last_d = last_q;
    if (enter_a) begin
      x_d    = 1'b0;
      last_d = LG_A;
    end else if (enter_b) begin
      x_d    = 1'b1;
      last_d = LG_B;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= 1'b0;
      last_q  <= LG_B;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      last_q  <= last_d;
    end
  end

  assign gnt_a = (state_q == OWN_A);
  assign gnt_b = (state_q == OWN_B);
  assign x     = x_q;
  assign y     = x_q ? b : a;
  assign busy  = gnt_a | gnt_b;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (MAX_HOLD >= 2 && MAX_HOLD <= 15
              && MAX_HOLD < (1 << CNT_W));
      assert (!(gnt_a && gnt_b));
    end
  end

endmodule

// File: tb/tb_mux2_arbiter.sv
// Scoreboard bench for mux2_arbiter: expected outputs are queued per
// driven cycle and checked 1 time unit after the following rising edge.
module tb_mux2_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic req_a;
  logic req_b;
  logic a;
  logic b;
  logic gnt_a;
  logic gnt_b;
  logic x;
  logic y;
  logic busy;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct packed {
    logic ga;
    logic gb;
    logic x;
    logic y;
    logic busy;
  } exp_t;

  exp_t sb_q[$];

  mux2_arbiter #(
    .MAX_HOLD(8),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_a(req_a),
    .req_b(req_b),
    .a(a),
    .b(b),
    .gnt_a(gnt_a),
    .gnt_b(gnt_b),
    .x(x),
    .y(y),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // row layout: {rst_n, req_a, req_b, a, b, exp_gnt_a, exp_gnt_b, exp_x}
  task automatic drive(input logic [7:0] r);
    exp_t e;
    rst_n = r[7];
    req_a = r[6];
    req_b = r[5];
    a     = r[4];
    b     = r[3];
    e.ga   = r[2];
    e.gb   = r[1];
    e.x    = r[0];
    e.y    = r[0] ? r[3] : r[4];
    e.busy = r[2] | r[1];
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    logic [7:0] tbl [4] = '{
      8'b0_11_00_000,
      8'b0_11_00_000,
      8'b1_11_10_100,
      8'b1_00_01_000
    };
    exp_t e;
    exp_t o;
    for (int i = 0; i < 4; i++) begin
      drive(tbl[i]);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      o = {gnt_a, gnt_b, x, y, busy};
      vec_cnt++;
      if (o !== e) begin
        err_cnt++;
        $display("FAIL reset[%0d] got %b want %b", i, o, e);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] tbl [4] = '{
      8'b1_11_01_011,
      8'b1_11_10_011,
      8'b1_10_10_100,
      8'b1_00_01_000
    };
    exp_t e;
    exp_t o;
    for (int i = 0; i < 4; i++) begin
      drive(tbl[i]);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      o = {gnt_a, gnt_b, x, y, busy};
      vec_cnt++;
      if (o !== e) begin
        err_cnt++;
        $display("FAIL round_robin[%0d] got %b want %b", i, o, e);
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] tbl [3] = '{
      8'b1_01_01_011,
      8'b1_00_01_001,
      8'b1_00_10_001
    };
    exp_t e;
    exp_t o;
    for (int i = 0; i < 3; i++) begin
      drive(tbl[i]);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      o = {gnt_a, gnt_b, x, y, busy};
      vec_cnt++;
      if (o !== e) begin
        err_cnt++;
        $display("FAIL single[%0d] got %b want %b", i, o, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] tbl [9] = '{
      8'b1_11_10_100,
      8'b1_01_10_011,
      8'b1_11_01_011,
      8'b1_10_01_100,
      8'b1_01_01_011,
      8'b1_10_11_100,
      8'b1_00_11_000,
      8'b1_11_11_011,
      8'b1_00_00_001
    };
    exp_t e;
    exp_t o;
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i]);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      o = {gnt_a, gnt_b, x, y, busy};
      vec_cnt++;
      if (o !== e) begin
        err_cnt++;
        $display("FAIL back_to_back[%0d] got %b want %b", i, o, e);
      end
    end
  endtask

  // entered with last owner B, so A wins the opening tie
  task automatic test_hold();
    exp_t e;
    exp_t o;
    int   n;
`ifdef MUX2_ARB_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      drive(8'b1_11_00_100);
    end
    drive(8'b1_11_00_011);
    drive(8'b1_11_00_011);
    drive(8'b1_00_00_001);
`else
    for (int i = 0; i < 50; i++) begin
      drive(8'b1_11_00_100);
    end
    drive(8'b1_00_00_000);
`endif
    n = sb_q.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      o = {gnt_a, gnt_b, x, y, busy};
      vec_cnt++;
      if (o !== e) begin
        err_cnt++;
        $display("FAIL hold[%0d] got %b want %b", i, o, e);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] tbl [5] = '{
      8'b1_01_01_011,
      8'b0_01_01_000,
      8'b0_11_11_000,
      8'b1_11_10_100,
      8'b1_00_00_000
    };
    exp_t e;
    exp_t o;
    for (int i = 0; i < 5; i++) begin
      drive(tbl[i]);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      o = {gnt_a, gnt_b, x, y, busy};
      vec_cnt++;
      if (o !== e) begin
        err_cnt++;
        $display("FAIL mid_reset[%0d] got %b want %b", i, o, e);
      end
    end
  endtask

  // test_hold stimulus drives ahead of the edges, so it runs on its own
  task automatic test_hold_wrap();
    exp_t e;
    exp_t o;
    int   steps;
`ifdef MUX2_ARB_TIMEOUT_EN
    steps = 11;
`else
    steps = 51;
`endif
    for (int i = 0; i < steps; i++) begin
      if (i < 8) begin
        drive(8'b1_11_00_100);
      end else begin
`ifdef MUX2_ARB_TIMEOUT_EN
        if (i < 10) begin
          drive(8'b1_11_00_011);
        end else begin
          drive(8'b1_00_00_001);
        end
`else
        if (i < 50) begin
          drive(8'b1_11_00_100);
        end else begin
          drive(8'b1_00_00_000);
        end
`endif
      end
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      o = {gnt_a, gnt_b, x, y, busy};
      vec_cnt++;
      if (o !== e) begin
        err_cnt++;
        $display("FAIL hold[%0d] got %b want %b", i, o, e);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;
    a     = 1'b0;
    b     = 1'b0;
    test_reset();
    test_round_robin();
    test_single();
    test_back_to_back();
    test_hold_wrap();
`ifdef MUX2_ARB_TIMEOUT_EN
    test_single();
`endif
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             vec_cnt, err_cnt);
    $finish;
  end

endmodule
